// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared constants and response entry type for the data RAM responder
// Purpose: default data-RAM window and the pipeline entry carried from accept to response.
// Ports: none (package).
package dmem_responder_pkg;

  localparam logic [31:0] DMEM_BASE_ADDR   = 32'h0001_0000;
  localparam int          DMEM_DEPTH_WORDS = 4096;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - LSU data bus interface with master (LSU) and slave (memory) views
// Purpose: bundles the data request/grant/response handshake.
// Ports: data_req/data_wr/data_addr/data_wdata/data_be (LSU to memory),
//        data_gnt/data_rdata/data_valid/data_error (memory to LSU).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        data_error;

  modport master (
    output data_req, data_wr, data_addr, data_wdata, data_be,
    input  data_gnt, data_rdata, data_valid, data_error
  );

  modport slave (
    input  data_req, data_wr, data_addr, data_wdata, data_be,
    output data_gnt, data_rdata, data_valid, data_error
  );

endinterface

// File: rtl/dmem_responder_sram.sv
// rtl/dmem_responder_sram.sv - single-port byte-enabled word array, synchronous write, async read
// Purpose: storage behind the responder; contents are never reset.
// Ports: clk, we (write strobe), addr (word index), wdata, be (byte enables), rdata (async read).
module dmem_sram #(
  parameter int    DEPTH_WORDS = 4096,
  parameter string INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  input  logic [3:0]                     be,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Async read gives the pre-write value of the same edge.
  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-side bus responder with fixed-latency, in-order responses
// Purpose: grants LSU requests against an outstanding limit, accesses the RAM at the
//          accept edge and returns {valid, err, rdata} LATENCY cycles later.
// Ports: clk, reset (async, active-high), stall (blocks new grants),
//        bus (slave side of dmem_responder_if), busy (requests outstanding).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS     = DMEM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR       = DMEM_BASE_ADDR,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter string       INIT_FILE       = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  dmem_responder_if.slave   bus,
  output logic              busy
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam int          CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  logic [CW-1:0] cnt_q, cnt_d;
  resp_t         pipe_q [LATENCY];
  resp_t         pipe_d [LATENCY];
  resp_t         out_resp;

  logic          accept;
  logic          hit;
  logic [32:0]   addr_ext;
  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic [31:0]   sram_rdata;
  logic          unused_offset;

  // Window test is done in 33 bits so a window ending at 4 GiB does not wrap.
  assign addr_ext      = {1'b0, bus.data_addr};
  assign hit           = (addr_ext >= {1'b0, BASE_ADDR}) && (addr_ext < WIN_END);
  assign offset        = bus.data_addr - BASE_ADDR;
  assign word_idx      = offset[AW+1:2];
  assign unused_offset = ^{offset[31:AW+2], offset[1:0]};

  assign bus.data_gnt = bus.data_req & ~stall & ~reset & (cnt_q < CW'(MAX_OUTSTANDING));
  assign accept       = bus.data_req & bus.data_gnt;

  dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_sram (
    .clk   (clk),
    .we    (accept & hit & bus.data_wr),
    .addr  (word_idx),
    .wdata (bus.data_wdata),
    .be    (bus.data_be),
    .rdata (sram_rdata)
  );

  assign out_resp = pipe_q[LATENCY-1];

  always_comb begin
    for (int i = 0; i < LATENCY; i++) pipe_d[i] = '0;
    cnt_d = cnt_q;

    // Stores and misses carry zero data; only hit loads return the word.
    pipe_d[0].valid = accept;
    pipe_d[0].err   = accept & ~hit;
    pipe_d[0].rdata = (accept & hit & ~bus.data_wr) ? sram_rdata : '0;
    for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];

    case ({accept, out_resp.valid})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pipe_q <= pipe_d;
    end
  end

  assign bus.data_valid = out_resp.valid;
  assign bus.data_error = out_resp.valid & out_resp.err;
  assign bus.data_rdata = out_resp.valid ? out_resp.rdata : '0;
  assign busy           = (cnt_q != '0);

  a_cnt_no_overflow: assert property (@(posedge clk) disable iff (reset)
    cnt_q <= CW'(MAX_OUTSTANDING));
  a_cnt_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(out_resp.valid && cnt_q == '0));

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder against a behavioural memory model
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int          LAT   = 3;
  localparam int          MAXO  = 2;
  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS     (DEPTH),
    .BASE_ADDR       (BASE),
    .LATENCY         (LAT),
    .MAX_OUTSTANDING (MAXO),
    .INIT_FILE       ("")
  ) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          due_q[$];
  logic [31:0] mem_m [DEPTH];
  int          words [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference: a request granted in cycle c is answered in cycle c+LAT;
  // stores commit immediately, loads see everything accepted before them.
  task automatic model_accept(input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
    longint      a   = longint'(addr);
    bit          hit = (a >= longint'(BASE)) && (a < longint'(BASE) + longint'(DEPTH) * 4);
    int          idx = 0;
    logic [31:0] rd  = 32'h0;
    exp_t        e;
    if (hit) idx = int'((a - longint'(BASE)) / 4);
    if (hit && !wr) rd = mem_m[idx];
    if (hit && wr)
      for (int i = 0; i < 4; i++) if (be[i]) mem_m[idx][8*i +: 8] = wdata[8*i +: 8];
    e.due = cyc + LAT; e.err = !hit; e.rdata = rd;
    exp_q.push_back(e);
    due_q.push_back(cyc + LAT);
  endtask

  // One bus cycle: drive after the rising edge, check grant/busy mid-cycle.
  task automatic step(input logic req, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input logic st,
                      output logic granted);
    logic exp_gnt;
    bus.data_req = req; bus.data_wr = wr; bus.data_addr = addr;
    bus.data_wdata = wdata; bus.data_be = be; stall = st;
    @(negedge clk);
    while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
    exp_gnt = req && !st && !reset && (due_q.size() < MAXO);
    chk("gnt", {31'h0, bus.data_gnt}, {31'h0, exp_gnt});
    chk("busy", {31'h0, busy}, {31'h0, due_q.size() != 0});
    granted = bus.data_gnt;
    if (granted) model_accept(wr, addr, wdata, be);
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    logic g = 1'b0;
    for (int n = 0; n < 20 && !g; n++) step(1'b1, wr, addr, wdata, be, 1'b0, g);
    if (!g) fail("issue_grant");
  endtask

  task automatic wait_idle();
    logic g;
    int   n = 0;
    while ((exp_q.size() != 0 || due_q.size() != 0) && n < 40) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, g);
      n++;
    end
    if (exp_q.size() != 0 || due_q.size() != 0) fail("idle_timeout");
  endtask

  // Monitor: every presented response must match the oldest expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (bus.data_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("resp_cycle", cyc, e.due);
        chk("resp_err", {31'h0, bus.data_error}, {31'h0, e.err});
        chk("resp_rdata", bus.data_rdata, e.rdata);
      end
    end else begin
      chk("rdata_idle", bus.data_rdata, 32'h0);
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        void'(exp_q.pop_front());
        checks++; errors++;
        $display("FAIL missing_valid: got valid=0 expected response (cycle %0d)", cyc);
      end
    end
  end

  initial begin
    logic        g;
    logic [5:0]  pat;
    logic [31:0] a;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_addr = 32'h0;
    bus.data_wdata = 32'h0; bus.data_be = 4'h0;
    for (int k = 0; k < 15; k++) words[k] = k;
    words[15] = DEPTH - 1;

    // Reset state.
    @(negedge clk); @(negedge clk);
    chk("rst_valid", {31'h0, bus.data_valid}, 32'h0);
    chk("rst_error", {31'h0, bus.data_error}, 32'h0);
    chk("rst_rdata", bus.data_rdata, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Give every word used by loads a known value.
    for (int k = 0; k < 16; k++) issue(1'b1, BASE + 32'(words[k]) * 4, $urandom, 4'hF);
    wait_idle();

    // Store then load, back to back.
    issue(1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 32'h0001_0010, 32'h0, 4'hF);
    // Byte lane merge.
    issue(1'b1, 32'h0001_0014, 32'h1122_3344, 4'hF);
    issue(1'b1, 32'h0001_0014, 32'h00AA_0000, 4'b0100);
    issue(1'b0, 32'h0001_0014, 32'h0, 4'hF);
    // Out of window, then the untouched first word; low address bits ignored; last word.
    issue(1'b0, 32'h0000_FFFC, 32'h0, 4'hF);
    issue(1'b1, 32'h0001_4000, 32'h5555_5555, 4'hF);
    issue(1'b0, 32'h0001_0000, 32'h0, 4'hF);
    issue(1'b0, 32'h0001_0013, 32'h0, 4'hF);
    issue(1'b1, 32'h0001_3FFC, 32'hA5A5_0000, 4'b1100);
    issue(1'b0, 32'h0001_3FFC, 32'h0, 4'hF);
    issue(1'b1, 32'h0001_0008, 32'hFFFF_FFFF, 4'h0);
    issue(1'b0, 32'h0001_0008, 32'h0, 4'hF);
    wait_idle();

    // Request held for 6 cycles against the outstanding limit.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 32'h0001_0010, 32'h0, 4'hF, 1'b0, g);
      pat[i] = g;
    end
    chk("gnt_pattern", {26'h0, pat}, {26'h0, 6'b110011});
    wait_idle();

    // Stall with one request in flight.
    issue(1'b0, 32'h0001_0014, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0001_0010, 32'h0, 4'hF, 1'b1, g);
    step(1'b1, 1'b0, 32'h0001_0010, 32'h0, 4'hF, 1'b0, g);
    chk("gnt_after_stall", {31'h0, g}, 32'h1);
    wait_idle();

    // Randomized traffic with back-pressure and abandoned requests.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 8)
        a = BASE + 32'(words[$urandom_range(0, 15)]) * 4 + 32'($urandom_range(0, 3));
      else
        case ($urandom_range(0, 3))
          0:       a = BASE - 32'd4;
          1:       a = BASE + DEPTH * 4;
          2:       a = 32'h0;
          default: a = 32'hFFFF_FFFC;
        endcase
      step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), a, $urandom,
           4'($urandom_range(0, 15)), $urandom_range(0, 9) < 2, g);
    end
    wait_idle();

    // Reset one cycle after a load accept; the earlier store must survive.
    issue(1'b1, 32'h0001_000C, 32'hCAFE_F00D, 4'hF);
    issue(1'b0, 32'h0001_000C, 32'h0, 4'hF);
    reset = 1'b1;
    exp_q.delete();
    due_q.delete();
    step(1'b1, 1'b0, 32'h0001_000C, 32'h0, 4'hF, 1'b0, g);
    step(1'b1, 1'b0, 32'h0001_000C, 32'h0, 4'hF, 1'b0, g);
    reset = 1'b0;
    for (int i = 0; i < LAT + 4; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, g);
    chk("busy_after_reset", {31'h0, busy}, 32'h0);
    issue(1'b0, 32'h0001_000C, 32'h0, 4'hF);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
